// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, decoded beside data memory.
// Optional feature macro UART_TX_IRQ_EN adds the CTRL register and a registered irq output.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q;

  state_e        state_q;
  logic [15:0]   bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [1:0]    offset;
  logic          wr_en;
  logic          fifo_empty;
  logic          fifo_full;
  logic          busy;
  logic          bit_done;
  logic          push_req;
  logic          push;
  logic          pop;
  logic [15:0]   div_eff;
  logic [15:0]   reload;
  logic [31:0]   rdata;
  logic [1:0]    ctrl_rd;

  // Byte lanes and upper store bits that no register uses.
  logic unused_bits;
  assign unused_bits = ^{DataAddr[1:0], WriteData[31:16]};

  assign sel    = (DataAddr[31:4] == BASE_ADDR[31:4]);
  assign offset = DataAddr[3:2];
  assign wr_en  = MemWrite && sel;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign busy       = (state_q != S_IDLE);
  assign bit_done   = (bit_cnt_q == 16'd0);

  // The transmitter pops in IDLE, or at the end of STOP for back-to-back frames.
  assign pop      = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && bit_done));
  assign push_req = wr_en && (offset == OFF_TXDATA);
  assign push     = push_req && (!fifo_full || pop);

  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign reload  = div_eff - 16'd1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    if (wr_en && offset == OFF_STATUS) ovf_d = 1'b0;
    else if (push_req && !push)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (wr_en && offset == OFF_DIV) div_q <= WriteData[15:0];
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= WriteData[7:0];
  end

  // Each bit lasts div_eff cycles: reload div_eff-1 at a boundary and count down to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q   <= mem_q[rptr_q];
            bit_cnt_q <= reload;
            state_q   <= S_START;
            tx_q      <= 1'b0;
          end
        end
        S_START: begin
          if (!bit_done) begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end else begin
            bit_cnt_q <= reload;
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
          end
        end
        S_DATA: begin
          if (!bit_done) begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end else begin
            bit_cnt_q <= reload;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (!bit_done) begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end else if (pop) begin
            shift_q   <= mem_q[rptr_q];
            bit_cnt_q <= reload;
            state_q   <= S_START;
            tx_q      <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_q;

`ifdef UART_TX_IRQ_EN
  logic [1:0] ctrl_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && offset == OFF_CTRL) ctrl_q <= WriteData[1:0];
      irq_q <= (ctrl_q[0] && fifo_empty && !busy) || (ctrl_q[1] && ovf_q);
    end
  end

  assign ctrl_rd = ctrl_q;
  assign irq     = irq_q;
`else
  assign ctrl_rd = 2'b00;
`endif

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (offset)
        OFF_STATUS: rdata = {28'd0, ovf_q, fifo_empty, fifo_full, busy};
        OFF_DIV:    rdata = {16'd0, div_q};
        OFF_CTRL:   rdata = {30'd0, ctrl_rd};
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign ReadData = rdata;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-level reference model plus directed and random bus traffic.
// Build with UART_TX_IRQ_EN defined to also exercise CTRL and irq.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 8;
  localparam logic [15:0] DIVR  = 16'd434;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAddr = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        sel;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DIV_RESET (DIVR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (MemWrite),
    .DataAddr (DataAddr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .sel      (sel),
    .tx       (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: bytes waiting, plus the frame in flight as (byte, cycles elapsed, divisor).
  logic [7:0]  m_q[$];
  bit          m_active;
  int          m_t;
  int          m_div_f;
  logic [7:0]  m_byte;
  logic        m_ovf;
  logic [15:0] m_div;
  logic [1:0]  m_ctrl;
  logic        m_irq;

  task automatic start_frame();
    m_byte   = m_q.pop_front();
    m_t      = 0;
    m_active = 1'b1;
    m_div_f  = (m_div == 16'd0) ? 1 : int'(m_div);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_div_f  = 1;
      m_byte   = 8'd0;
      m_ovf    = 1'b0;
      m_div    = DIVR;
      m_ctrl   = 2'b00;
      m_irq    = 1'b0;
    end else begin
      m_irq = (m_ctrl[0] && m_q.size() == 0 && !m_active) || (m_ctrl[1] && m_ovf);
      if (m_active) begin
        m_t++;
        if (m_t == 10 * m_div_f) begin
          if (m_q.size() > 0) start_frame();
          else m_active = 1'b0;
        end
      end else if (m_q.size() > 0) begin
        start_frame();
      end
      if (MemWrite && DataAddr[31:4] == BASE[31:4]) begin
        case (DataAddr[3:2])
          2'd0: if (m_q.size() < DEPTH) m_q.push_back(WriteData[7:0]); else m_ovf = 1'b1;
          2'd1: m_ovf = 1'b0;
          2'd2: m_div = WriteData[15:0];
          default: begin
`ifdef UART_TX_IRQ_EN
            m_ctrl = WriteData[1:0];
`endif
          end
        endcase
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / m_div_f;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
    if (addr[31:4] != BASE[31:4]) return 32'd0;
    case (addr[3:2])
      2'd1: return {28'd0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_active};
      2'd2: return {16'd0, m_div};
      2'd3: return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, mid-low-phase, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("tx", {31'd0, tx}, {31'd0, exp_tx()});
      check("sel", {31'd0, sel}, {31'd0, DataAddr[31:4] == BASE[31:4]});
      check("rdata", ReadData, exp_rdata(DataAddr));
`ifdef UART_TX_IRQ_EN
      check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    end
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = we;
    DataAddr  = addr;
    WriteData = data;
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    drive(we, addr, data);
  endtask

  task automatic idle();
    bus(1'b0, BASE + 32'd4, $urandom);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < bound) begin
      idle();
      n++;
    end
    check("drain_timeout", {31'd0, m_active || m_q.size() != 0}, 32'd0);
  endtask

  logic [9:0] bits;
  int         cnt;
  int         r;

  initial begin
    // Reset and post-reset register values.
    repeat (3) @(negedge clk);
    check("tx_in_reset", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    idle(); #2;
    check("status_after_reset", ReadData, 32'h4);
    bus(1'b0, BASE + 32'd8, 32'd0); #2;
    check("div_after_reset", ReadData, 32'd434);
    check("tx_after_reset", {31'd0, tx}, 32'd1);

    // DIV=4, one byte 0xA5: bits sampled once per bit time.
    bus(1'b1, BASE + 32'd8, 32'd4);
    bus(1'b1, BASE, 32'hA5);
    bits = '0;
    for (int i = 1; i <= 42; i++) begin
      idle(); #2;
      if (i >= 2 && i <= 38 && (i - 2) % 4 == 0) bits[(i - 2) / 4] = tx;
      if (i == 41) check("a5_busy_at_40", {31'd0, ReadData[0]}, 32'd1);
      if (i == 42) check("a5_idle_after_40", ReadData, 32'h4);
    end
    check("a5_frame_bits", {22'd0, bits}, 32'h34A);

    // DIV=2, ten pushes: the tenth lands on a full FIFO and is dropped.
    bus(1'b1, BASE + 32'd8, 32'd2);
    for (int k = 0; k < 10; k++) bus(1'b1, BASE, 32'h10 + k);
    idle(); #2;
    check("status_full_ovf", ReadData, 32'hB);
    wait_idle(400);
    idle(); #2;
    check("status_drained_ovf", ReadData, 32'hC);
    bus(1'b1, BASE + 32'd4, 32'hFFFF_FFFF);
    idle(); #2;
    check("status_ovf_cleared", ReadData, 32'h4);

    // Asynchronous reset during data bit 3 of 0x42 (that bit is 0).
    bus(1'b1, BASE + 32'd8, 32'd4);
    bus(1'b1, BASE, 32'h42);
    for (int i = 1; i <= 18; i++) idle();
    #2;
    check("tx_before_reset", {31'd0, tx}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("tx_forced_by_reset", {31'd0, tx}, 32'd1);
    check("status_in_reset", ReadData, 32'h4);
    idle();
    idle();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      idle(); #2;
      if (!tx) cnt++;
    end
    check("no_residual_frame", cnt, 32'd0);
    check("status_after_midreset", ReadData, 32'h4);

    // DIV=0 behaves as 1: a 0x00 frame is 9 low cycles then the stop bit.
    bus(1'b1, BASE + 32'd8, 32'd0);
    bus(1'b1, BASE, 32'h00);
    cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      idle(); #2;
      if (!tx) cnt++;
      if (i == 11) check("div0_busy_at_10", {31'd0, ReadData[0]}, 32'd1);
      if (i == 12) check("div0_idle_after_10", ReadData, 32'h4);
    end
    check("div0_low_cycles", cnt, 32'd9);

    // Just past the window: not selected, reads 0, store ignored.
    bus(1'b1, BASE + 32'd16, 32'h55); #2;
    check("outside_sel", {31'd0, sel}, 32'd0);
    check("outside_rdata", ReadData, 32'd0);
    bus(1'b0, BASE + 32'd20, 32'd0); #2;
    check("outside_read", ReadData, 32'd0);
    repeat (4) idle();
    #2;
    check("outside_no_push", ReadData, 32'h4);

`ifdef UART_TX_IRQ_EN
    // txe interrupt around one frame, then ovf interrupt until STATUS is written.
    bus(1'b1, BASE + 32'd8, 32'd2);
    bus(1'b1, BASE + 32'd12, 32'd1);
    idle(); idle(); #2;
    check("irq_txe_idle", {31'd0, irq}, 32'd1);
    bus(1'b1, BASE, 32'h3C);
    for (int i = 1; i <= 23; i++) begin
      idle(); #2;
      if (i == 2)  check("irq_low_busy", {31'd0, irq}, 32'd0);
      if (i == 22) check("irq_low_at_idle_entry", {31'd0, irq | ReadData[0]}, 32'd0);
      if (i == 23) check("irq_high_after_idle", {31'd0, irq}, 32'd1);
    end
    bus(1'b1, BASE + 32'd12, 32'd2);
    for (int k = 0; k < 10; k++) bus(1'b1, BASE, 32'hA0 + k);
    idle(); idle(); #2;
    check("irq_ovf_set", {31'd0, irq}, 32'd1);
    bus(1'b1, BASE + 32'd4, 32'd0);
    idle(); idle(); #2;
    check("irq_ovf_cleared", {31'd0, irq}, 32'd0);
    wait_idle(400);
`else
    bus(1'b1, BASE + 32'd12, 32'd3);
    bus(1'b0, BASE + 32'd12, 32'd0); #2;
    check("ctrl_reads_zero", ReadData, 32'd0);
`endif

    // Random traffic; DIV only changes while the transmitter is idle and empty.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 30)
        drive(1'b1, BASE, $urandom);
      else if (r < 33)
        drive(1'b1, BASE + 32'd4, $urandom);
      else if (r < 38 && !m_active && m_q.size() == 0)
        drive(1'b1, BASE + 32'd8, 32'($urandom_range(0, 3)));
      else if (r < 41)
        drive(1'b1, BASE + 32'd12, $urandom);
      else if (r < 46)
        drive(1'($urandom_range(0, 1)), $urandom | 32'h8000_0000, $urandom);
      else
        drive(1'b0, BASE | 32'($urandom_range(0, 15)), $urandom);
    end
    wait_idle(400);
    idle(); #2;
    check("final_idle_busy", {31'd0, ReadData[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
